// File: rtl/cci_mpf_shim_pkg.sv
// Shared types and elaboration-time parameter checks for the MPF shim request buffer.
package cci_mpf_shim_pkg;

    // Upper bound on buffer depth; the count typedef is sized to hold any legal occupancy.
    localparam int CCI_MPF_REQ_BUF_MAX_ENTRIES = 1024;

    typedef logic [$clog2(CCI_MPF_REQ_BUF_MAX_ENTRIES + 1) - 1:0] t_cci_mpf_req_buf_count;

    function automatic bit cci_mpf_req_buf_params_ok(input int n_entries, input int slack);
        return (n_entries >= 4) &&
               (n_entries <= CCI_MPF_REQ_BUF_MAX_ENTRIES) &&
               ((n_entries & (n_entries - 1)) == 0) &&
               (slack >= 0) &&
               (slack < n_entries - 1);
    endfunction

endpackage

// File: rtl/cci_mpf_prim_lutram_fifo_storage.sv
// N_ENTRIES x DATA_WIDTH storage: clocked write port, combinational read port.
module cci_mpf_prim_lutram_fifo_storage
    import cci_mpf_shim_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int N_ENTRIES  = 16,
    localparam int PTR_W     = $clog2(N_ENTRIES)
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read in the same cycle as a write to the same slot returns the old entry.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cci_mpf_shim_req_buffer.sv
// Request-channel buffer between the AFU and MPF: absorbs requests issued under
// flow control and registers both sides to break the AFU-to-shim timing path.
module cci_mpf_shim_req_buffer
    import cci_mpf_shim_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int N_ENTRIES  = 16,
    parameter int SLACK      = 4,
    localparam int CNT_W     = $clog2(N_ENTRIES + 1)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  afu_req_valid,
    input  logic [DATA_WIDTH-1:0] afu_req_data,
    output logic                  afu_alm_full,
    output logic                  mpf_req_valid,
    output logic [DATA_WIDTH-1:0] mpf_req_data,
    input  logic                  mpf_alm_full,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow_err
);

    localparam int PTR_W = $clog2(N_ENTRIES);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);
    localparam t_cci_mpf_req_buf_count ALM_THRESH =
        t_cci_mpf_req_buf_count'(N_ENTRIES - SLACK);

    if (!cci_mpf_req_buf_params_ok(N_ENTRIES, SLACK)) begin : g_bad_params
        $error("cci_mpf_shim_req_buffer: N_ENTRIES must be a power of 2 >= 4 and SLACK < N_ENTRIES-1");
    end

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   enq;
    logic                   deq;
    logic                   drop;
    t_cci_mpf_req_buf_count count_next;
    logic [DATA_WIDTH-1:0]  rd_data;

    cci_mpf_prim_lutram_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_ENTRIES  (N_ENTRIES)
    ) storage (
        .clk     (clk),
        .wr_en   (enq),
        .wr_addr (wr_ptr),
        .wr_data (afu_req_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Full/empty come from the registered count; a same-cycle dequeue frees a slot at full.
    always_comb begin
        deq        = (count != '0) && !mpf_alm_full;
        enq        = afu_req_valid && ((count != FULL_CNT) || deq);
        drop       = afu_req_valid && !enq;
        count_next = t_cci_mpf_req_buf_count'(count)
                   + t_cci_mpf_req_buf_count'(enq)
                   - t_cci_mpf_req_buf_count'(deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            mpf_req_valid <= 1'b0;
            mpf_req_data  <= '0;
            afu_alm_full  <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                mpf_req_data  <= rd_data;
                mpf_req_valid <= 1'b1;
            end else begin
                mpf_req_valid <= 1'b0;
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
            count        <= count_next[CNT_W-1:0];
            afu_alm_full <= (count_next >= ALM_THRESH);
        end
    end

    assign fifo_count = count;

endmodule

// File: doc/cci_mpf_shim_req_buffer.md
Name: cci_mpf_shim_req_buffer

Overview:
- Request-channel buffer between the AFU and the MPF stack's AFU-facing request port, one instance per request channel (c0 read, c1 write).
- Absorbs requests that the AFU issues after flow control asserts, and throttles the AFU with an almost-full signal that has slack.
- Drains into MPF only while MPF's almost-full is deasserted.
- Registered outputs on both sides break the timing path between the AFU and the shim stack.

Parameters:
- DATA_WIDTH, default 128: packed request width (header plus any payload carried on this channel).
- N_ENTRIES, default 16: storage depth; must be a power of 2 and at least 4.
- SLACK, default 4: number of requests the AFU may still issue after afu_alm_full asserts; must be less than N_ENTRIES - 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- afu_req_valid  in  1  AFU request strobe; the request is offered this cycle.
- afu_req_data  in  DATA_WIDTH  AFU request payload.
- afu_alm_full  out  1  back-pressure to the AFU, registered.
- mpf_req_valid  out  1  request strobe toward MPF, registered.
- mpf_req_data  out  DATA_WIDTH  request payload toward MPF, registered.
- mpf_alm_full  in  1  back-pressure from MPF.
- fifo_count  out  $clog2(N_ENTRIES+1)  current occupancy of the storage.
- overflow_err  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset:
  - Synchronous and active-high; it overrides every other event in the same cycle.
  - Read/write pointers, count, mpf_req_valid, mpf_req_data, afu_alm_full and overflow_err all go to 0.
  - Entries in flight at reset are discarded silently; no partial output is produced.
- Enqueue:
  - Accepted when afu_req_valid=1 and either count<N_ENTRIES or a dequeue occurs in the same cycle.
  - Data is written at wr_ptr; wr_ptr increments and wraps modulo N_ENTRIES.
- Overflow:
  - afu_req_valid=1 with count==N_ENTRIES and no same-cycle dequeue: the request is dropped and overflow_err is set.
  - overflow_err stays at 1 until reset.
  - Storage and pointers are unchanged.
- Dequeue decision:
  - deq = (count!=0) && !mpf_alm_full, evaluated on registered count.
  - On deq, mpf_req_data <= storage[rd_ptr], mpf_req_valid <= 1, and rd_ptr increments with wrap.
  - Otherwise mpf_req_valid <= 0 and mpf_req_data holds its value.
- Latency:
  - Enqueue in cycle t: count reflects it in t+1; the earliest mpf_req_valid is t+2.
  - Throughput is 1 request per cycle in steady state.
- Count update: count_next = count + enq - deq.
  - Simultaneous enqueue and dequeue leaves count unchanged, including at full and at empty+1.
  - Enqueue at empty with no dequeue gives count=1 (there is no bypass path).
- Almost-full: afu_alm_full <= (count_next >= N_ENTRIES - SLACK).
  - It therefore asserts in the cycle after the threshold-crossing enqueue.
  - It deasserts in the cycle after count_next drops below the threshold.
- Ordering: strict FIFO; no reordering and no payload inspection.
- mpf_alm_full: honoured only in the dequeue decision.
  - The block relies on MPF's own slack for a request already registered on mpf_req_valid.
- fifo_count equals the registered count.
- Pointer widths are $clog2(N_ENTRIES). Full and empty are distinguished by count, not by pointer equality.

Decomposition:
- Package cci_mpf_shim_pkg holds:
  - t_cci_mpf_req_buf_count, a typedef of width $clog2(N_ENTRIES+1);
  - the elaboration-time parameter checks (power-of-2 depth, SLACK range) as a shared function or macro.
- One sub-module, cci_mpf_prim_lutram_fifo_storage: N_ENTRIES x DATA_WIDTH memory.
  - Write port: registered address/data/enable.
  - Read port: combinational read at rd_ptr.
  - Pointer, count and flow-control logic stay in the top module.

Test Plan:
- Reset then idle; N_ENTRIES=16, SLACK=4: all outputs 0, fifo_count=0.
- Single request 0xA5 at cycle 10 with mpf_alm_full=0: mpf_req_valid=1 with data 0xA5 at cycle 12 only; fifo_count is 1 at cycle 11 and 0 at cycle 12.
- Fill and almost-full, mpf_alm_full=1, 12 back-to-back requests: afu_alm_full=1 the cycle after the 12th enqueue.
  - Issue 4 more: fifo_count=16, overflow_err=0.
  - A 17th request sets overflow_err=1 and fifo_count stays 16.
- Drain, from the full state with mpf_alm_full dropped to 0: 16 consecutive mpf_req_valid pulses in enqueue order (values 1..16).
  - afu_alm_full clears the cycle after count_next=11.
- Simultaneous enqueue/dequeue at full: with count=16, deq active and afu_req_valid=1, the request is accepted, count stays 16, overflow_err stays 0, and order is preserved across pointer wrap.
- Reset mid-operation with count=9: reset for 1 cycle gives count=0, mpf_req_valid=0 and overflow_err=0; old data never appears on mpf_req_data.
